// File: rtl/hv_pwm_intb_encode.sv
// HV-side PWM/INTB encoder: turns each HV interrupt level change into an edge burst
// (1 toggle for assert, 3 toggles for deassert) followed by a quiet hold.
module hv_pwm_intb_encode #(
    parameter int EDGE_GAP_CYC = 6,
    parameter int QUIET_CYC    = 16,
    parameter int CNT_W        = $clog2(((EDGE_GAP_CYC > QUIET_CYC) ? EDGE_GAP_CYC : QUIET_CYC) + 1)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_hv_intb_n,
    output logic o_hv_pwm_intb_n,
    output logic o_busy,
    output logic o_burst_done,
    output logic o_rpt_intb_n
);

    typedef enum logic [1:0] {IDLE, GAP, QUIET} state_t;

    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(EDGE_GAP_CYC);
    localparam logic [CNT_W-1:0] QUIET_END = CNT_W'(QUIET_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       tog, tog_nx;
    logic             line, line_nx;
    logic             rpt, rpt_nx;
    logic             busy, busy_nx;
    logic             done, done_nx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
            tog   <= '0;
            line  <= 1'b1;
            rpt   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            tog   <= tog_nx;
            line  <= line_nx;
            rpt   <= rpt_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tog_nx   = tog;
        line_nx  = line;
        rpt_nx   = rpt;
        busy_nx  = busy;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                // The level is committed at burst start; changes during the burst
                // are only re-evaluated once we are back here.
                if (i_en && (i_hv_intb_n != rpt)) begin
                    rpt_nx   = i_hv_intb_n;
                    line_nx  = ~line;
                    tog_nx   = i_hv_intb_n ? 2'd2 : 2'd0;
                    cnt_nx   = CNT_ONE;
                    busy_nx  = 1'b1;
                    state_nx = i_hv_intb_n ? GAP : QUIET;
                end
            end
            GAP: begin
                if (cnt == GAP_END) begin
                    line_nx = ~line;
                    tog_nx  = tog - 2'd1;
                    cnt_nx  = CNT_ONE;
                    if (tog == 2'd1) state_nx = QUIET;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            QUIET: begin
                if (cnt == QUIET_END) begin
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                tog_nx   = '0;
            end
        endcase
    end

    assign o_hv_pwm_intb_n = line;
    assign o_busy          = busy;
    assign o_burst_done    = done;
    assign o_rpt_intb_n    = rpt;

endmodule
